// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver and decoder.
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } rx_state_t;

  localparam logic [7:0] PS2_BRK = 8'hF0;
  localparam logic [7:0] PS2_EXT = 8'hE0;

  localparam logic [15:0] KEY_SPACE     = 16'd32;
  localparam logic [15:0] KEY_NEWLINE   = 16'd128;
  localparam logic [15:0] KEY_BACKSPACE = 16'd129;
  localparam logic [15:0] KEY_LEFT      = 16'd130;
  localparam logic [15:0] KEY_UP        = 16'd131;
  localparam logic [15:0] KEY_RIGHT     = 16'd132;
  localparam logic [15:0] KEY_DOWN      = 16'd133;
  localparam logic [15:0] KEY_HOME      = 16'd134;
  localparam logic [15:0] KEY_END       = 16'd135;
  localparam logic [15:0] KEY_PGUP      = 16'd136;
  localparam logic [15:0] KEY_PGDN      = 16'd137;
  localparam logic [15:0] KEY_INSERT    = 16'd138;
  localparam logic [15:0] KEY_DELETE    = 16'd139;
  localparam logic [15:0] KEY_ESC       = 16'd140;
  localparam logic [15:0] KEY_F1        = 16'd141;
  localparam logic [15:0] KEY_F2        = 16'd142;
  localparam logic [15:0] KEY_F3        = 16'd143;
  localparam logic [15:0] KEY_F4        = 16'd144;
  localparam logic [15:0] KEY_F5        = 16'd145;
  localparam logic [15:0] KEY_F6        = 16'd146;
  localparam logic [15:0] KEY_F7        = 16'd147;
  localparam logic [15:0] KEY_F8        = 16'd148;
  localparam logic [15:0] KEY_F9        = 16'd149;
  localparam logic [15:0] KEY_F10       = 16'd150;
  localparam logic [15:0] KEY_F11       = 16'd151;
  localparam logic [15:0] KEY_F12       = 16'd152;

endpackage

// File: rtl/ps2_xlate.sv
// Scan-code set 2 to Hack key code translation; 0 means unmapped.
module ps2_xlate
  import ps2_pkg::*;
(
  input  logic        ext_i,
  input  logic [7:0]  scancode_i,
  output logic [15:0] hack_code_o
);

  // Lookup on the (extended, scancode) pair
  always_comb begin
    hack_code_o = 16'd0;
    case ({ext_i, scancode_i})
      9'h01C: hack_code_o = 16'd65;  9'h032: hack_code_o = 16'd66;
      9'h021: hack_code_o = 16'd67;  9'h023: hack_code_o = 16'd68;
      9'h024: hack_code_o = 16'd69;  9'h02B: hack_code_o = 16'd70;
      9'h034: hack_code_o = 16'd71;  9'h033: hack_code_o = 16'd72;
      9'h043: hack_code_o = 16'd73;  9'h03B: hack_code_o = 16'd74;
      9'h042: hack_code_o = 16'd75;  9'h04B: hack_code_o = 16'd76;
      9'h03A: hack_code_o = 16'd77;  9'h031: hack_code_o = 16'd78;
      9'h044: hack_code_o = 16'd79;  9'h04D: hack_code_o = 16'd80;
      9'h015: hack_code_o = 16'd81;  9'h02D: hack_code_o = 16'd82;
      9'h01B: hack_code_o = 16'd83;  9'h02C: hack_code_o = 16'd84;
      9'h03C: hack_code_o = 16'd85;  9'h02A: hack_code_o = 16'd86;
      9'h01D: hack_code_o = 16'd87;  9'h022: hack_code_o = 16'd88;
      9'h035: hack_code_o = 16'd89;  9'h01A: hack_code_o = 16'd90;
      9'h045: hack_code_o = 16'd48;  9'h016: hack_code_o = 16'd49;
      9'h01E: hack_code_o = 16'd50;  9'h026: hack_code_o = 16'd51;
      9'h025: hack_code_o = 16'd52;  9'h02E: hack_code_o = 16'd53;
      9'h036: hack_code_o = 16'd54;  9'h03D: hack_code_o = 16'd55;
      9'h03E: hack_code_o = 16'd56;  9'h046: hack_code_o = 16'd57;
      9'h029: hack_code_o = KEY_SPACE;
      9'h05A: hack_code_o = KEY_NEWLINE;
      9'h066: hack_code_o = KEY_BACKSPACE;
      9'h076: hack_code_o = KEY_ESC;
      9'h16B: hack_code_o = KEY_LEFT;
      9'h175: hack_code_o = KEY_UP;
      9'h174: hack_code_o = KEY_RIGHT;
      9'h172: hack_code_o = KEY_DOWN;
      9'h16C: hack_code_o = KEY_HOME;
      9'h169: hack_code_o = KEY_END;
      9'h17D: hack_code_o = KEY_PGUP;
      9'h17A: hack_code_o = KEY_PGDN;
      9'h170: hack_code_o = KEY_INSERT;
      9'h171: hack_code_o = KEY_DELETE;
      9'h005: hack_code_o = KEY_F1;  9'h006: hack_code_o = KEY_F2;
      9'h004: hack_code_o = KEY_F3;  9'h00C: hack_code_o = KEY_F4;
      9'h003: hack_code_o = KEY_F5;  9'h00B: hack_code_o = KEY_F6;
      9'h083: hack_code_o = KEY_F7;  9'h00A: hack_code_o = KEY_F8;
      9'h001: hack_code_o = KEY_F9;  9'h009: hack_code_o = KEY_F10;
      9'h078: hack_code_o = KEY_F11; 9'h007: hack_code_o = KEY_F12;
      default: hack_code_o = 16'd0;
    endcase
  end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver: sync + clock filter, frame FSM, make/break decoder.
module ps2_keyboard
  import ps2_pkg::*;
#(
  parameter int unsigned FILT    = 8,
  parameter int unsigned TIMEOUT = 50000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ps2_clk,
  input  logic        ps2_dat,
  output logic [15:0] key,
  output logic        frame_err
);

  localparam int unsigned FW = $clog2(FILT + 1);
  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  logic          clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q;
  logic          filt_q, filt_d;
  logic [FW-1:0] fcnt_q, fcnt_d;
  logic          fall_c;
  rx_state_t     state_q, state_d;
  logic [2:0]    bcnt_q, bcnt_d;
  logic [7:0]    shreg_q, shreg_d;
  logic          par_q, par_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          byte_vld_q, byte_vld_d;
  logic [7:0]    byte_q, byte_d;
  logic          err_q, err_d;
  logic          brk_q, brk_d, ext_q, ext_d;
  logic [15:0]   key_q, key_d;
  logic [15:0]   code_c;

  assign key       = key_q;
  assign frame_err = err_q;

  ps2_xlate u_xlate (
    .ext_i      (ext_q),
    .scancode_i (byte_q),
    .hack_code_o(code_c)
  );

  // Two-flop synchronisers for the asynchronous PS/2 lines
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_s1_q <= 1'b1; clk_s2_q <= 1'b1;
      dat_s1_q <= 1'b1; dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= ps2_clk; clk_s2_q <= clk_s1_q;
      dat_s1_q <= ps2_dat; dat_s2_q <= dat_s1_q;
    end
  end

  // Clock filter: level follows only after FILT consecutive differing samples
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    fall_c = 1'b0;
    if (clk_s2_q != filt_q) begin
      if (fcnt_q == FW'(FILT - 1)) begin
        filt_d = clk_s2_q;
        fall_c = filt_q;
      end else begin
        fcnt_d = fcnt_q + FW'(1);
      end
    end
  end

  // Frame receiver, timeout and make/break decoder next-state
  always_comb begin
    state_d    = state_q;
    bcnt_d     = bcnt_q;
    shreg_d    = shreg_q;
    par_d      = par_q;
    tcnt_d     = tcnt_q;
    byte_vld_d = 1'b0;
    byte_d     = byte_q;
    err_d      = 1'b0;
    brk_d      = brk_q;
    ext_d      = ext_q;
    key_d      = key_q;

    if (byte_vld_q) begin
      if (byte_q == PS2_BRK) begin
        brk_d = 1'b1;
      end else if (byte_q == PS2_EXT) begin
        ext_d = 1'b1;
      end else begin
        brk_d = 1'b0;
        ext_d = 1'b0;
        if (code_c != 16'd0) begin
          if (!brk_q) key_d = code_c;
          else if (code_c == key_q) key_d = 16'd0;
        end
      end
    end

    if (fall_c) begin
      tcnt_d = '0;
      case (state_q)
        IDLE: begin
          if (!dat_s2_q) begin
            state_d = DATA;
            bcnt_d  = 3'd0;
          end else begin
            err_d = 1'b1;
          end
        end
        DATA: begin
          shreg_d = {dat_s2_q, shreg_q[7:1]};
          bcnt_d  = bcnt_q + 3'd1;
          if (bcnt_q == 3'd7) state_d = PARITY;
        end
        PARITY: begin
          par_d   = dat_s2_q;
          state_d = STOP;
        end
        STOP: begin
          state_d = IDLE;
          if (dat_s2_q && ((^shreg_q) ^ par_q)) begin
            byte_vld_d = 1'b1;
            byte_d     = shreg_q;
          end else begin
            err_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q != IDLE) begin
      if (tcnt_q == TW'(TIMEOUT - 1)) begin
        state_d = IDLE;
        tcnt_d  = '0;
        err_d   = 1'b1;
      end else begin
        tcnt_d = tcnt_q + TW'(1);
      end
    end else begin
      tcnt_d = '0;
    end

    // A damaged or aborted frame may have been a prefix; forget pending prefixes
    if (err_d) begin
      brk_d = 1'b0;
      ext_d = 1'b0;
    end
  end

  // State registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q     <= 1'b1;
      fcnt_q     <= '0;
      state_q    <= IDLE;
      bcnt_q     <= 3'd0;
      shreg_q    <= 8'd0;
      par_q      <= 1'b0;
      tcnt_q     <= '0;
      byte_vld_q <= 1'b0;
      byte_q     <= 8'd0;
      err_q      <= 1'b0;
      brk_q      <= 1'b0;
      ext_q      <= 1'b0;
      key_q      <= 16'd0;
    end else begin
      filt_q     <= filt_d;
      fcnt_q     <= fcnt_d;
      state_q    <= state_d;
      bcnt_q     <= bcnt_d;
      shreg_q    <= shreg_d;
      par_q      <= par_d;
      tcnt_q     <= tcnt_d;
      byte_vld_q <= byte_vld_d;
      byte_q     <= byte_d;
      err_q      <= err_d;
      brk_q      <= brk_d;
      ext_q      <= ext_d;
      key_q      <= key_d;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// Self-checking bench for ps2_keyboard: frame table plus hand-written corner cases.
module tb_ps2_keyboard;
  import ps2_pkg::*;

  localparam int unsigned TMO = 2000;
  localparam int unsigned H   = 20;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        ps2_clk = 1'b1;
  logic        ps2_dat = 1'b1;
  logic [15:0] key;
  logic        frame_err;

  int n_chk = 0;
  int n_pass = 0;
  int err_cnt = 0;
  int run = 0;

  typedef struct {
    logic [15:0] key;
    int          errs;
  } exp_t;

  typedef struct {
    logic [7:0]  code;
    bit          bad_par;
    bit          bad_stop;
    logic [15:0] exp_key;
    int          exp_err;
  } vec_t;

  exp_t sb[$];
  vec_t vt[33];

  always #5 clk = ~clk;

  ps2_keyboard #(.FILT(8), .TIMEOUT(TMO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ps2_clk  (ps2_clk),
    .ps2_dat  (ps2_dat),
    .key      (key),
    .frame_err(frame_err)
  );

  task automatic check(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
  endtask

  // Count frame_err pulses and check each is exactly one cycle wide
  always @(negedge clk) begin
    if (frame_err) begin
      run++;
      if (run == 1) err_cnt++;
    end else if (run != 0) begin
      n_chk++;
      if (run == 1) n_pass++;
      else $display("FAIL err_width actual=%0d required=1", run);
      run = 0;
    end
  end

  task automatic send_bits(input logic [7:0] b, input bit bad_par, input bit bad_stop,
                           input int nbits);
    logic [10:0] bits;
    bits = {~bad_stop, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_dat = bits[i];
      repeat (H) @(negedge clk);
      ps2_clk = 1'b0;
      repeat (H) @(negedge clk);
      ps2_clk = 1'b1;
    end
    ps2_dat = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic sb_check(input string nm, input int err_before);
    exp_t x;
    x = sb.pop_front();
    check({nm, "_key"}, int'(key), int'(x.key));
    check({nm, "_err"}, err_cnt - err_before, x.errs);
  endtask

  task automatic frame(input string nm, input logic [7:0] b, input logic [15:0] k);
    int e0;
    e0 = err_cnt;
    sb.push_back('{k, 0});
    send_bits(b, 1'b0, 1'b0, 11);
    repeat (40) @(negedge clk);
    sb_check(nm, e0);
  endtask

  initial begin
    int e0;
    vt[0]  = '{8'hF0, 1'b0, 1'b0, 16'd65,  0};
    vt[1]  = '{8'h1C, 1'b0, 1'b0, 16'd0,   0};
    vt[2]  = '{8'hE0, 1'b0, 1'b0, 16'd0,   0};
    vt[3]  = '{8'h6B, 1'b0, 1'b0, 16'd130, 0};
    vt[4]  = '{8'hE0, 1'b0, 1'b0, 16'd130, 0};
    vt[5]  = '{8'hF0, 1'b0, 1'b0, 16'd130, 0};
    vt[6]  = '{8'h6B, 1'b0, 1'b0, 16'd0,   0};
    vt[7]  = '{8'h1C, 1'b0, 1'b0, 16'd65,  0};
    vt[8]  = '{8'h1C, 1'b1, 1'b0, 16'd65,  1};
    vt[9]  = '{8'h32, 1'b0, 1'b0, 16'd66,  0};
    vt[10] = '{8'hF0, 1'b0, 1'b0, 16'd66,  0};
    vt[11] = '{8'h1C, 1'b0, 1'b0, 16'd66,  0};
    vt[12] = '{8'hF0, 1'b0, 1'b0, 16'd66,  0};
    vt[13] = '{8'h32, 1'b0, 1'b0, 16'd0,   0};
    vt[14] = '{8'h15, 1'b0, 1'b0, 16'd81,  0};
    vt[15] = '{8'h45, 1'b0, 1'b0, 16'd48,  0};
    vt[16] = '{8'h0E, 1'b0, 1'b0, 16'd48,  0};
    vt[17] = '{8'h05, 1'b0, 1'b0, 16'd141, 0};
    vt[18] = '{8'h07, 1'b0, 1'b0, 16'd152, 0};
    vt[19] = '{8'hE0, 1'b0, 1'b0, 16'd152, 0};
    vt[20] = '{8'h71, 1'b0, 1'b0, 16'd139, 0};
    vt[21] = '{8'h66, 1'b0, 1'b0, 16'd129, 0};
    vt[22] = '{8'h76, 1'b0, 1'b0, 16'd140, 0};
    vt[23] = '{8'h29, 1'b0, 1'b0, 16'd32,  0};
    vt[24] = '{8'h1C, 1'b0, 1'b1, 16'd32,  1};
    vt[25] = '{8'h5A, 1'b0, 1'b0, 16'd128, 0};
    vt[26] = '{8'hE0, 1'b0, 1'b0, 16'd128, 0};
    vt[27] = '{8'h75, 1'b0, 1'b0, 16'd131, 0};
    vt[28] = '{8'hF0, 1'b0, 1'b0, 16'd131, 0};
    vt[29] = '{8'h32, 1'b0, 1'b0, 16'd131, 0};
    vt[30] = '{8'hE0, 1'b0, 1'b0, 16'd131, 0};
    vt[31] = '{8'h1C, 1'b1, 1'b0, 16'd131, 1};
    vt[32] = '{8'h6B, 1'b0, 1'b0, 16'd131, 0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_key", int'(key), 0);
    check("rst_err", int'(frame_err), 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // First make with latency window around the stop-bit edge
    e0 = err_cnt;
    sb.push_back('{16'd65, 0});
    send_bits(8'h1C, 1'b0, 1'b0, 10);
    ps2_dat = 1'b1;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (4) @(negedge clk);
    check("lat_early_key", int'(key), 0);
    repeat (20) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (H) @(negedge clk);
    sb_check("lat_a", e0);

    // Table of frames
    for (int i = 0; i < 33; i++) begin
      e0 = err_cnt;
      sb.push_back('{vt[i].exp_key, vt[i].exp_err});
      send_bits(vt[i].code, vt[i].bad_par, vt[i].bad_stop, 11);
      repeat (40) @(negedge clk);
      sb_check($sformatf("vec%0d", i), e0);
    end

    // Start-bit error: falling clock with data high
    e0 = err_cnt;
    sb.push_back('{16'd131, 1});
    ps2_dat = 1'b1;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (H) @(negedge clk);
    ps2_clk = 1'b1;
    repeat (40) @(negedge clk);
    sb_check("start_err", e0);

    // Timeout after a partial frame, then a good frame
    e0 = err_cnt;
    sb.push_back('{16'd131, 1});
    send_bits(8'h1C, 1'b0, 1'b0, 5);
    repeat (TMO + 10) @(negedge clk);
    sb_check("timeout", e0);
    check("timeout_idle", int'(dut.state_q), int'(IDLE));
    frame("after_tmo", 8'h5A, 16'd128);

    // Reset in the middle of a frame
    frame("pre_rst", 8'h1C, 16'd65);
    send_bits(8'h32, 1'b0, 1'b0, 3);
    check("mid_state", int'(dut.state_q), int'(DATA));
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_key", int'(key), 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    frame("after_rst", 8'h29, 16'd32);

    check("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
